// File: rtl/level_sequencer_pkg.sv
// Shared game-flow types for the tile-map datapath: tile codes, sequencer states,
// map geometry and tile-index helpers (also used by the map controller).
package level_sequencer_pkg;

  localparam int NUM_OF_ROWS = 7;
  localparam int NUM_OF_COLS = 10;
  localparam int TILE_X_W    = 4;
  localparam int TILE_Y_W    = 3;
  localparam int PORT_W      = 4;
  localparam int MASK_W      = NUM_OF_ROWS * NUM_OF_COLS;
  localparam int IDX_W       = $clog2(MASK_W);
  localparam int FRAME_W     = 8;
  localparam int LVL_W       = 2;
  localparam int LIVES_W     = 2;
  localparam int COINS_W     = 4;

  typedef enum logic [2:0] {
    T_FREE = 3'd0,
    T_REGU = 3'd1,
    T_GATE = 3'd2,
    T_COIN = 3'd3,
    T_PORT = 3'd4,
    T_SPIK = 3'd5,
    T_BRAK = 3'd6
  } tile_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_TELEPORT,
    S_DYING,
    S_LEVEL_DONE,
    S_WIN,
    S_GAME_OVER
  } state_e;

  function automatic logic tile_in_range(input logic [TILE_X_W-1:0] x,
                                         input logic [TILE_Y_W-1:0] y);
    return (x < TILE_X_W'(NUM_OF_COLS)) && (y < TILE_Y_W'(NUM_OF_ROWS));
  endfunction

  // Row-major linear index into the per-level coin mask.
  function automatic logic [IDX_W-1:0] tile_idx(input logic [TILE_X_W-1:0] x,
                                                input logic [TILE_Y_W-1:0] y);
    return IDX_W'(y) * IDX_W'(NUM_OF_COLS) + IDX_W'(x);
  endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Bumpy/map-controller/HUD signal bundle around the level sequencer.
// LEVEL_SKIP_EN adds the skip_level request line.
interface level_sequencer_if;
  import level_sequencer_pkg::*;

  logic                start;
  logic                frame_tick;
  logic                bumpy_landed;
  logic [TILE_X_W-1:0] bumpy_tile_x;
  logic [TILE_Y_W-1:0] bumpy_tile_y;
  logic [2:0]          step_type;
  logic [7:0]          teleport_cordinates;
`ifdef LEVEL_SKIP_EN
  logic                skip_level;
`endif

  logic [LVL_W-1:0]    lvl;
  logic                gate;
  logic                map_reloadN;
  logic                coin_clear;
  logic [TILE_X_W-1:0] coin_x;
  logic [TILE_Y_W-1:0] coin_y;
  logic                teleport_req;
  logic [PORT_W-1:0]   teleport_x;
  logic [PORT_W-1:0]   teleport_y;
  logic                freeze;
  logic [LIVES_W-1:0]  lives;
  logic [COINS_W-1:0]  coins;
  logic                game_over;
  logic                game_won;

  modport master (
    output start, frame_tick, bumpy_landed, bumpy_tile_x, bumpy_tile_y,
           step_type, teleport_cordinates,
`ifdef LEVEL_SKIP_EN
    output skip_level,
`endif
    input  lvl, gate, map_reloadN, coin_clear, coin_x, coin_y, teleport_req,
           teleport_x, teleport_y, freeze, lives, coins, game_over, game_won
  );

  modport slave (
    input  start, frame_tick, bumpy_landed, bumpy_tile_x, bumpy_tile_y,
           step_type, teleport_cordinates,
`ifdef LEVEL_SKIP_EN
    input  skip_level,
`endif
    output lvl, gate, map_reloadN, coin_clear, coin_x, coin_y, teleport_req,
           teleport_x, teleport_y, freeze, lives, coins, game_over, game_won
  );

endinterface

// File: rtl/level_sequencer_frame_timer.sv
// Loadable frame counter shared by the teleport, dying and level-done waits.
// done fires on the tick that brings the count to limit-1.
module frame_timer
  import level_sequencer_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         clear,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;
  logic [W-1:0] cnt_inc;

  assign cnt_inc = count + W'(1);
  assign done    = tick & ~clear & (cnt_inc == limit - W'(1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)    count <= '0;
    else if (clear) count <= '0;
    else if (tick)  count <= cnt_inc;
  end

endmodule

// File: rtl/level_sequencer.sv
// Game-flow controller: owns level, gate, map reload, coins, lives and teleports.
// Build with LEVEL_SKIP_EN to honour a rising edge on skip_level during play.
module level_sequencer
  import level_sequencer_pkg::*;
#(
  parameter int NUM_OF_LEVELS      = 4,
  parameter int START_LIVES        = 3,
  parameter int COINS_TO_OPEN_GATE = 3,
  parameter int DEATH_FRAMES       = 60,
  parameter int TELEPORT_FRAMES    = 8,
  parameter int LEVEL_DONE_FRAMES  = 90
) (
  input logic               clk,
  input logic               resetN,
  level_sequencer_if.slave  bus
);

  state_e              state, state_nxt;
  logic [LVL_W-1:0]    lvl;
  logic                gate;
  logic                map_reloadN;
  logic [LIVES_W-1:0]  lives;
  logic [COINS_W-1:0]  coins, coins_inc;
  logic [MASK_W-1:0]   coin_mask;
  logic                coin_clear;
  logic [TILE_X_W-1:0] coin_x;
  logic [TILE_Y_W-1:0] coin_y;
  logic                teleport_req;
  logic [PORT_W-1:0]   teleport_x, teleport_y;
  logic                freeze, game_over, game_won;

  logic                landed, in_range, last_lvl;
  tile_e               step;
  logic [IDX_W-1:0]    idx;
  logic                coin_hit, spike_hit, port_hit, gate_hit, skip_rise;
  logic                timed, timer_done;
  logic [FRAME_W-1:0]  timer_lim;

  // Landings off the 10x7 grid behave like empty tiles.
  assign landed    = (state == S_PLAY) & bus.bumpy_landed;
  assign in_range  = tile_in_range(bus.bumpy_tile_x, bus.bumpy_tile_y);
  assign step      = in_range ? tile_e'(bus.step_type) : T_FREE;
  assign idx       = tile_idx(bus.bumpy_tile_x, bus.bumpy_tile_y);
  assign coin_hit  = landed & (step == T_COIN) & ~coin_mask[idx];
  assign spike_hit = landed & (step == T_SPIK);
  assign port_hit  = landed & (step == T_PORT);
  assign gate_hit  = landed & (step == T_GATE) & gate;
  assign coins_inc = (coins == '1) ? coins : coins + COINS_W'(1);
  assign last_lvl  = (lvl == LVL_W'(NUM_OF_LEVELS - 1));

`ifdef LEVEL_SKIP_EN
  logic skip_q;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) skip_q <= 1'b0;
    else         skip_q <= bus.skip_level;
  end
  assign skip_rise = (state == S_PLAY) & bus.skip_level & ~skip_q;
`else
  assign skip_rise = 1'b0;
`endif

  // Timer is held clear outside the timed states, so it restarts on every entry.
  assign timed = (state == S_TELEPORT) | (state == S_DYING) | (state == S_LEVEL_DONE);

  frame_timer #(.W(FRAME_W)) u_timer (
    .clk    (clk),
    .resetN (resetN),
    .clear  (~timed),
    .tick   (bus.frame_tick),
    .limit  (timer_lim),
    .done   (timer_done)
  );

  always_comb begin
    state_nxt = state;
    timer_lim = FRAME_W'(TELEPORT_FRAMES);
    case (state)
      S_DYING:      timer_lim = FRAME_W'(DEATH_FRAMES);
      S_LEVEL_DONE: timer_lim = FRAME_W'(LEVEL_DONE_FRAMES);
      default:      timer_lim = FRAME_W'(TELEPORT_FRAMES);
    endcase
    case (state)
      S_IDLE:       if (bus.start) state_nxt = S_LOAD;
      S_LOAD:       state_nxt = S_PLAY;
      // Landing events win over a coincident skip request.
      S_PLAY: begin
        if (spike_hit)                  state_nxt = S_DYING;
        else if (port_hit)              state_nxt = S_TELEPORT;
        else if (gate_hit || skip_rise) state_nxt = S_LEVEL_DONE;
      end
      S_TELEPORT:   if (timer_done) state_nxt = S_PLAY;
      S_DYING:      if (timer_done) state_nxt = (lives == '0) ? S_GAME_OVER : S_LOAD;
      S_LEVEL_DONE: if (timer_done) state_nxt = last_lvl ? S_WIN : S_LOAD;
      S_WIN,
      S_GAME_OVER:  if (bus.start) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered off the next state so they line up with it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= S_IDLE;
      freeze      <= 1'b1;
      map_reloadN <= 1'b1;
      game_over   <= 1'b0;
      game_won    <= 1'b0;
    end else begin
      state       <= state_nxt;
      freeze      <= (state_nxt != S_PLAY);
      map_reloadN <= (state_nxt != S_LOAD);
      game_over   <= (state_nxt == S_GAME_OVER);
      game_won    <= (state_nxt == S_WIN);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lvl          <= '0;
      gate         <= 1'b0;
      lives        <= LIVES_W'(START_LIVES);
      coins        <= '0;
      coin_mask    <= '0;
      coin_clear   <= 1'b0;
      coin_x       <= '0;
      coin_y       <= '0;
      teleport_req <= 1'b0;
      teleport_x   <= '0;
      teleport_y   <= '0;
    end else begin
      coin_clear   <= 1'b0;
      teleport_req <= 1'b0;
      if (state == S_IDLE && bus.start) begin
        lvl   <= '0;
        lives <= LIVES_W'(START_LIVES);
      end
      if (state == S_LOAD) begin
        coins     <= '0;
        coin_mask <= '0;
        gate      <= 1'b0;
      end
      if (coin_hit) begin
        coin_mask[idx] <= 1'b1;
        coins          <= coins_inc;
        coin_clear     <= 1'b1;
        coin_x         <= bus.bumpy_tile_x;
        coin_y         <= bus.bumpy_tile_y;
        if (coins_inc == COINS_W'(COINS_TO_OPEN_GATE)) gate <= 1'b1;
      end
      if (spike_hit && lives != '0) lives <= lives - LIVES_W'(1);
      if (port_hit) begin
        teleport_x   <= bus.teleport_cordinates[7:4];
        teleport_y   <= bus.teleport_cordinates[3:0];
        teleport_req <= 1'b1;
      end
      if (state == S_LEVEL_DONE && timer_done && !last_lvl) lvl <= lvl + LVL_W'(1);
    end
  end

  assign bus.lvl          = lvl;
  assign bus.gate         = gate;
  assign bus.map_reloadN  = map_reloadN;
  assign bus.coin_clear   = coin_clear;
  assign bus.coin_x       = coin_x;
  assign bus.coin_y       = coin_y;
  assign bus.teleport_req = teleport_req;
  assign bus.teleport_x   = teleport_x;
  assign bus.teleport_y   = teleport_y;
  assign bus.freeze       = freeze;
  assign bus.lives        = lives;
  assign bus.coins        = coins;
  assign bus.game_over    = game_over;
  assign bus.game_won     = game_won;

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench for level_sequencer: stimulus queues expected reload/coin/teleport
// events, a negedge monitor pops and compares them when the DUT emits one.
module tb_level_sequencer;
  import level_sequencer_pkg::*;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  level_sequencer_if bus();
  level_sequencer dut (.clk(clk), .resetN(resetN), .bus(bus));

  int checks = 0;
  int errors = 0;

  // kind 0: reload {lvl, lives}; 1: coin {x, y, coins, gate}; 2: teleport {x, y}
  typedef struct { int kind; int a; int b; int c; int d; } ev_t;
  ev_t q[$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(int kind, int a, int b, int c, int d);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c; e.d = d;
    q.push_back(e);
  endtask

  task automatic mon(int kind, int a, int b, int c, int d);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event kind=%0d actual_a=%0d actual_b=%0d required=none", kind, a, b);
    end else begin
      e = q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_a", a, e.a);
      chk("ev_b", b, e.b);
      chk("ev_c", c, e.c);
      chk("ev_d", d, e.d);
    end
  endtask

  always @(negedge clk) begin
    if (resetN) begin
      if (!bus.map_reloadN) mon(0, bus.lvl, bus.lives, 0, 0);
      if (bus.coin_clear)   mon(1, bus.coin_x, bus.coin_y, bus.coins, bus.gate);
      if (bus.teleport_req) mon(2, bus.teleport_x, bus.teleport_y, 0, 0);
    end
  end

  task automatic land(int t, int x, int y, logic [7:0] cord);
    bus.bumpy_landed        = 1'b1;
    bus.step_type           = 3'(t);
    bus.bumpy_tile_x        = 4'(x);
    bus.bumpy_tile_y        = 3'(y);
    bus.teleport_cordinates = cord;
    @(negedge clk);
    bus.bumpy_landed = 1'b0;
    @(negedge clk);
  endtask

  task automatic frames(int n);
    repeat (n) begin
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  // Collect three coins, prove a closed gate is ignored, then take the open gate.
  task automatic clear_level(int cur);
    land(T_GATE, 0, 1, 8'h00);
    chk("closed_gate_ignored", bus.freeze, 0);
    push(1, 1, 0, 1, 0); land(T_COIN, 1, 0, 8'h00);
    push(1, 2, 0, 2, 0); land(T_COIN, 2, 0, 8'h00);
    push(1, 3, 0, 3, 1); land(T_COIN, 3, 0, 8'h00);
    land(T_GATE, 0, 1, 8'h00);
    chk("level_done_freeze", bus.freeze, 1);
    if (cur < 3) push(0, cur + 1, 3, 0, 0);
    frames(89);
    chk("lvl_after_done", bus.lvl, (cur < 3) ? cur + 1 : 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.frame_tick = 1'b0; bus.bumpy_landed = 1'b0;
    bus.bumpy_tile_x = '0; bus.bumpy_tile_y = '0; bus.step_type = '0;
    bus.teleport_cordinates = '0;
`ifdef LEVEL_SKIP_EN
    bus.skip_level = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_lvl", bus.lvl, 0);           chk("rst_gate", bus.gate, 0);
    chk("rst_reloadN", bus.map_reloadN, 1); chk("rst_lives", bus.lives, 3);
    chk("rst_coins", bus.coins, 0);       chk("rst_freeze", bus.freeze, 1);
    chk("rst_coin_clear", bus.coin_clear, 0); chk("rst_tp_req", bus.teleport_req, 0);
    chk("rst_tp_x", bus.teleport_x, 0);   chk("rst_tp_y", bus.teleport_y, 0);
    chk("rst_over", bus.game_over, 0);    chk("rst_won", bus.game_won, 0);
    resetN = 1'b1;
    @(negedge clk);

    // Start: one-cycle reload, freeze falls two cycles later
    push(0, 0, 3, 0, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("freeze_in_load", bus.freeze, 1);
    @(negedge clk);
    chk("freeze_in_play", bus.freeze, 0);
    chk("start_lvl", bus.lvl, 0);
    chk("start_lives", bus.lives, 3);

    // Coins: repeat and off-grid landings produce nothing
    push(1, 3, 3, 1, 0); land(T_COIN, 3, 3, 8'h00);
    land(T_COIN, 3, 3, 8'h00);
    chk("coin_repeat", bus.coins, 1);
    land(T_COIN, 10, 0, 8'h00);
    land(T_COIN, 0, 7, 8'h00);
    chk("coin_offgrid", bus.coins, 1);
    push(1, 5, 2, 2, 0); land(T_COIN, 5, 2, 8'h00);
    push(1, 9, 6, 3, 1); land(T_COIN, 9, 6, 8'h00);
    chk("coins_three", bus.coins, 3);
    chk("gate_open", bus.gate, 1);

    // Spikes: lives 2,1,0 then game over
    land(T_SPIK, 0, 0, 8'h00);
    chk("lives_2", bus.lives, 2);
    chk("dying_freeze", bus.freeze, 1);
    land(T_COIN, 0, 0, 8'h00);
    push(0, 0, 2, 0, 0);
    frames(58);
    chk("dying_hold", bus.freeze, 1);
    frames(1);
    chk("replay_freeze", bus.freeze, 0);
    chk("reload_coins", bus.coins, 0);
    chk("reload_gate", bus.gate, 0);
    land(T_SPIK, 0, 0, 8'h00);
    chk("lives_1", bus.lives, 1);
    push(0, 0, 1, 0, 0);
    frames(59);
    land(T_SPIK, 0, 0, 8'h00);
    chk("lives_0", bus.lives, 0);
    frames(59);
    chk("game_over", bus.game_over, 1);
    chk("over_freeze", bus.freeze, 1);
    pulse_start();
    chk("over_to_idle", bus.game_over, 0);
    chk("idle_freeze", bus.freeze, 1);

    // Teleport
    push(0, 0, 3, 0, 0);
    pulse_start();
    push(2, 4, 5, 0, 0);
    land(T_PORT, 2, 2, 8'h45);
    chk("tp_x", bus.teleport_x, 4);
    chk("tp_y", bus.teleport_y, 5);
    chk("tp_freeze", bus.freeze, 1);
    frames(6);
    chk("tp_hold", bus.freeze, 1);
    frames(1);
    chk("tp_release", bus.freeze, 0);

    // Levels 0..3 then win
    for (int l = 0; l < 4; l++) clear_level(l);
    chk("game_won", bus.game_won, 1);
    chk("won_freeze", bus.freeze, 1);
    pulse_start();
    chk("won_to_idle", bus.game_won, 0);

    // Async reset while dying, then landings in idle are ignored
    push(0, 0, 3, 0, 0);
    pulse_start();
    land(T_SPIK, 0, 0, 8'h00);
    chk("pre_rst_lives", bus.lives, 2);
    frames(10);
    #2 resetN = 1'b0;
    #1;
    chk("arst_lives", bus.lives, 3);
    chk("arst_freeze", bus.freeze, 1);
    chk("arst_reloadN", bus.map_reloadN, 1);
    chk("arst_lvl", bus.lvl, 0);
    chk("arst_coins", bus.coins, 0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    land(T_SPIK, 0, 0, 8'h00);
    land(T_COIN, 1, 1, 8'h00);
    chk("idle_lives", bus.lives, 3);
    chk("idle_coins", bus.coins, 0);
    chk("idle_still_frozen", bus.freeze, 1);

    repeat (2) @(negedge clk);
    chk("sb_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
- Game-flow controller that sequences the tile-map datapath: owns the current level, the gate-open flag, map reload, coin bookkeeping, lives and teleport requests.
- Consumes the tile type under Bumpy's landing point and drives the map/tile controller's lvl, gate and active-low map reload.
- Also drives freeze/status signals to the Bumpy movement and HUD blocks.
- Sits between the Bumpy physics block and the tile-map controller; it is the only writer of lvl and gate.

Parameters:
- NUM_OF_LEVELS, 4, number of levels; lvl wraps to a win at NUM_OF_LEVELS-1.
- START_LIVES, 3, lives loaded on game start.
- COINS_TO_OPEN_GATE, 3, coins collected in a level before gate asserts.
- DEATH_FRAMES, 60, frames frozen after a spike hit.
- TELEPORT_FRAMES, 8, frames frozen during teleport.
- LEVEL_DONE_FRAMES, 90, frames frozen between levels.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- start  in  1  level-sensitive start/restart request
- frame_tick  in  1  one-cycle pulse per video frame (startOfFrame)
- bumpy_landed  in  1  one-cycle pulse when Bumpy lands on a tile
- bumpy_tile_x  in  4  column index (0..9) of landed tile
- bumpy_tile_y  in  3  row index (0..6) of landed tile
- step_type  in  3  tile code of landed tile (FREE=0, REGU=1, GATE=2, COIN=3, PORT=4, SPIK=5, BRAK=6)
- teleport_cordinates  in  8  {X[3:0], Y[3:0]} target of landed PORT tile
- lvl  out  2  current level to map controller
- gate  out  1  gate-open flag to map controller
- map_reloadN  out  1  active-low one-cycle map reload pulse
- coin_clear  out  1  one-cycle pulse: coin at coin_x/coin_y collected
- coin_x  out  4 / coin_y  out  3  collected coin tile index
- teleport_req  out  1  one-cycle pulse: move Bumpy to teleport_x/teleport_y
- teleport_x  out  4 / teleport_y  out  4  latched teleport target tile
- freeze  out  1  high while Bumpy motion must halt
- lives  out  2  remaining lives
- coins  out  4  coins collected this level, saturating at 15
- game_over  out  1  high in S_GAME_OVER
- game_won  out  1  high in S_WIN

Behaviour:
- Reset: state S_IDLE, lvl=0, gate=0, map_reloadN=1, lives=START_LIVES, coins=0, coin mask=0, freeze=1, all pulses 0, teleport_x/y=0, frame counter=0.
- S_IDLE: freeze=1. On start: lvl<=0, lives<=START_LIVES, then S_LOAD.
- S_LOAD: lasts exactly 1 cycle.
  - map_reloadN=0 for that cycle.
  - coins<=0, 70-bit coin mask<=0, gate<=0.
  - Next state S_PLAY.
- S_PLAY: freeze=0. Events are sampled only on bumpy_landed; the response registers 1 cycle after the pulse.
  - COIN, mask bit clear: set mask bit, coins+1 (saturating), coin_clear pulse with coin_x/y. When the new count reaches COINS_TO_OPEN_GATE, gate<=1 in the same cycle.
  - COIN, mask bit already set: ignored.
  - SPIK: lives-1 (floor 0), go to S_DYING.
  - PORT: latch teleport_x=cord[7:4], teleport_y=cord[3:0], teleport_req pulse, go to S_TELEPORT.
  - GATE with gate=1: go to S_LEVEL_DONE. GATE with gate=0: ignored.
  - FREE, REGU, BRAK, and codes 7/undefined: no action.
- Timed states S_TELEPORT, S_DYING, S_LEVEL_DONE:
  - freeze=1. Frame counter clears on entry and increments on frame_tick.
  - Exit on the tick that makes counter == N-1 (N = that state's FRAMES parameter).
  - S_TELEPORT exits to S_PLAY.
  - S_DYING exits to S_GAME_OVER if lives==0, else to S_LOAD (same lvl).
  - S_LEVEL_DONE exits to S_WIN if lvl==NUM_OF_LEVELS-1, else lvl+1 and S_LOAD.
- S_WIN / S_GAME_OVER: freeze=1, status flag high. On start: return to S_IDLE, then proceed as above.
- Ignored inputs:
  - bumpy_landed outside S_PLAY.
  - start outside S_IDLE/S_WIN/S_GAME_OVER.
  - Tile index out of range (x>9 or y>6): treated as FREE.
- frame_tick coincident with bumpy_landed in S_PLAY: both honoured; the counter is irrelevant in S_PLAY.
- Asynchronous reset mid-level returns to the reset values immediately; no pulse is emitted.

Optional Feature:
- LEVEL_SKIP_EN defined: adds input skip_level (1 bit). A rising edge of skip_level in S_PLAY forces S_LEVEL_DONE as if an open gate were reached.
- LEVEL_SKIP_EN undefined: the port is absent and the skip logic is not built.

Decomposition:
- Shared package (used by the map controller too): tile code enum (FREE..BRAK), game state enum, NUM_OF_ROWS=7, NUM_OF_COLS=10, tile-index widths.
- One sub-module, frame_timer: loadable frame counter with done output, reused for all three timed states.

Test Plan:
- Reset, start pulse → map_reloadN low for exactly 1 cycle, lvl=0, lives=3, freeze drops 2 cycles after start.
- Land on COIN (3,3) twice, then on two other coins → coins=3, coin_clear only 3 times, gate=1 on the third.
- Land on SPIK three times with DEATH_FRAMES elapsed each time → lives 2,1,0; game_over=1 after the third timeout, start → S_IDLE.
- Land on PORT with cord 8'h45 → teleport_req pulse, teleport_x=4, teleport_y=5, freeze for 8 frames then 0.
- Open gate on lvl=3, land on GATE → 90 frames later game_won=1; on lvl=1 the same sequence gives lvl=2 plus a reload pulse.
- Assert resetN low during S_DYING → all outputs at reset values; bumpy_landed in S_IDLE produces no response.
